ds1302_responder: RTL

//  Synthesizable DS1302 device-side responder: answers the 3-wire CE/SCLK/IO protocol driven by our ds1302 master stack.

---
 rtl/ds1302_pkg.sv | 51 +++++
 rtl/ds1302_bcd_clock.sv | 84 ++++++++
 rtl/ds1302_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds1302_pkg.sv
// DS1302 responder shared definitions:
// register addresses, command bits, FSM states, reset values.
package ds1302_pkg;

   localparam logic [4:0] ADDR_SEC   = 5'd0;
   localparam logic [4:0] ADDR_MIN   = 5'd1;
   localparam logic [4:0] ADDR_HOUR  = 5'd2;
   localparam logic [4:0] ADDR_DATE  = 5'd3;
   localparam logic [4:0] ADDR_MONTH = 5'd4;
   localparam logic [4:0] ADDR_DAY   = 5'd5;
   localparam logic [4:0] ADDR_YEAR  = 5'd6;
   localparam logic [4:0] ADDR_CTRL  = 5'd7;
   localparam logic [4:0] ADDR_TCS   = 5'd8;
   localparam logic [4:0] ADDR_BURST = 5'd31;

   localparam int CMD_RD   = 0;
   localparam int CMD_RAM  = 6;
   localparam int CMD_MARK = 7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] RST_SEC   = 8'h80;
   localparam logic [7:0] RST_MIN   = 8'h00;
   localparam logic [5:0] RST_HOUR  = 6'h00;
   localparam logic [7:0] RST_DATE  = 8'h01;
   localparam logic [7:0] RST_MONTH = 8'h01;
   localparam logic [7:0] RST_DAY   = 8'h01;
   localparam logic [7:0] RST_YEAR  = 8'h00;
   localparam logic [7:0] RST_TCS   = 8'h00;

   // BCD increment with wrap at vmax; bit 8 is the carry out.
   // A low nibble of 9 or more carries so odd values still progress.
   function automatic logic [8:0] bcd_inc(
      input logic [7:0] v,
      input logic [7:0] vmax
   );
      if (v >= vmax)
         return 9'h100;
      else if (v[3:0] >= 4'd9)
         return {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/ds1302_bcd_clock.sv
// DS1302 timekeeper: 1 Hz prescaler and BCD sec/min/hour
// counters; register writes override the same-cycle increment.
module ds1302_bcd_clock
   import ds1302_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr_sec,
   input  logic       i_wr_min,
   input  logic       i_wr_hour,
   input  logic [7:0] i_wdata,
   output logic [7:0] o_sec,
   output logic [7:0] o_min,
   output logic [5:0] o_hour,
   output logic       o_tick
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] P_TOP = PW'(CLK_HZ - 1);

   logic [PW-1:0] r_presc;
   logic [7:0]    r_sec;
   logic [7:0]    r_min;
   logic [5:0]    r_hour;
   logic          r_tick;

   logic       w_wrap;
   logic       w_run;
   logic [8:0] w_sec_n;
   logic [8:0] w_min_n;
   logic       w_sec_c;
   logic       w_min_c;

   assign w_wrap  = (r_presc == P_TOP);
   assign w_run   = w_wrap & ~r_sec[7];
   assign w_sec_n = bcd_inc(r_sec, 8'h59);
   assign w_min_n = bcd_inc(r_min, 8'h59);
   assign w_sec_c = w_run & w_sec_n[8];
   assign w_min_c = w_sec_c & w_min_n[8];

   // Free-running prescaler, restarted whenever seconds are written
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         if (i_wr_sec || w_wrap)
            r_presc <= '0;
         else
            r_presc <= r_presc + PW'(1);
      end
   end

   // Time registers: a write wins, carries from lower digits still ripple
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sec  <= RST_SEC;
         r_min  <= RST_MIN;
         r_hour <= RST_HOUR;
      end else begin
         if (i_wr_sec)
            r_sec <= i_wdata;
         else if (w_run)
            r_sec <= w_sec_n[7:0];
         if (i_wr_min)
            r_min <= i_wdata;
         else if (w_sec_c)
            r_min <= w_min_n[7:0];
         if (i_wr_hour)
            r_hour <= i_wdata[5:0];
         else if (w_min_c)
            r_hour <= 6'(bcd_inc({2'b00, r_hour}, 8'h23));
      end
   end

   assign o_sec  = r_sec;
   assign o_min  = r_min;
   assign o_hour = r_hour;
   assign o_tick = r_tick;

endmodule

// File: rtl/ds1302_responder.sv
// DS1302 device-side responder: 3-wire protocol FSM and register file.
// Define DS1302_RAM_EN to add the 31-byte user RAM.
module ds1302_responder
   import ds1302_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int SYNC_STG = 2
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic ds_ce,
   input  logic ds_sclk,
   input  logic ds_io_in,
   output logic ds_io_out,
   output logic ds_io_oe,
   output logic access_done,
   output logic tick_1hz
);

   logic [SYNC_STG-1:0] r_ce_sync;
   logic [SYNC_STG-1:0] r_sclk_sync;
   logic [SYNC_STG-1:0] r_io_sync;
   logic                r_ce_d;
   logic                r_sclk_d;

   logic w_ce_s;
   logic w_sclk_s;
   logic w_io_s;
   logic w_ce_rise;
   logic w_sclk_rise;
   logic w_sclk_fall;

   state_t     r_state;
   state_t     w_state_n;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_n;
   logic [6:0] r_shift;
   logic [6:0] w_shift_n;
   logic [7:0] r_rdata;
   logic [7:0] w_rdata_n;
   logic       r_cmd_ram;
   logic       w_cmd_ram_n;
   logic [4:0] r_cmd_addr;
   logic [4:0] w_cmd_addr_n;
   logic       r_io_out;
   logic       w_io_out_n;
   logic       r_oe;
   logic       w_oe_n;
   logic       r_done;
   logic       w_done_n;
   logic       w_commit;

   logic [7:0] w_byte;
   logic [4:0] w_addr;
   logic [7:0] w_rd_val;
   logic       w_blocked;

   logic [7:0] r_date;
   logic [7:0] r_month;
   logic [7:0] r_day;
   logic [7:0] r_year;
   logic [7:0] r_tcs;
   logic       r_wp;

   logic [7:0] w_sec;
   logic [7:0] w_min;
   logic [5:0] w_hour;
   logic       w_wr_ck;
   logic       w_wr_sec;
   logic       w_wr_min;
   logic       w_wr_hour;

   // Bring the asynchronous pins into sys_clk, plus one stage for edges
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_ce_sync   <= '0;
         r_sclk_sync <= '0;
         r_io_sync   <= '0;
         r_ce_d      <= 1'b0;
         r_sclk_d    <= 1'b0;
      end else begin
         r_ce_sync   <= {r_ce_sync[SYNC_STG-2:0], ds_ce};
         r_sclk_sync <= {r_sclk_sync[SYNC_STG-2:0], ds_sclk};
         r_io_sync   <= {r_io_sync[SYNC_STG-2:0], ds_io_in};
         r_ce_d      <= w_ce_s;
         r_sclk_d    <= w_sclk_s;
      end
   end

   assign w_ce_s      = r_ce_sync[SYNC_STG-1];
   assign w_sclk_s    = r_sclk_sync[SYNC_STG-1];
   assign w_io_s      = r_io_sync[SYNC_STG-1];
   assign w_ce_rise   = w_ce_s & ~r_ce_d;
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

   // Byte as it stands once the current bit is shifted in
   assign w_byte = {w_io_s, r_shift};
   assign w_addr = w_byte[5:1];

   assign w_blocked = r_wp &
      ~(~r_cmd_ram & (r_cmd_addr == ADDR_CTRL));

`ifdef DS1302_RAM_EN
   logic [7:0] r_ram [0:30];

   // User RAM, written only by unprotected RAM commits
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 31; i++)
            r_ram[i] <= 8'h00;
      end else if (w_commit && r_cmd_ram) begin
         r_ram[r_cmd_addr] <= w_byte;
      end
   end
`endif

   // Read value selected by the command being decoded
   always_comb begin
      w_rd_val = 8'h00;
      if (!w_byte[CMD_RAM]) begin
         case (w_addr)
            ADDR_SEC:   w_rd_val = w_sec;
            ADDR_MIN:   w_rd_val = w_min;
            ADDR_HOUR:  w_rd_val = {2'b00, w_hour};
            ADDR_DATE:  w_rd_val = r_date;
            ADDR_MONTH: w_rd_val = r_month;
            ADDR_DAY:   w_rd_val = r_day;
            ADDR_YEAR:  w_rd_val = r_year;
            ADDR_CTRL:  w_rd_val = {r_wp, 7'b0};
            ADDR_TCS:   w_rd_val = r_tcs;
            default:    w_rd_val = 8'h00;
         endcase
      end
`ifdef DS1302_RAM_EN
      else if (w_addr != ADDR_BURST) begin
         w_rd_val = r_ram[w_addr];
      end
`endif
   end

   // Protocol FSM registers
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_shift    <= 7'd0;
         r_rdata    <= 8'h00;
         r_cmd_ram  <= 1'b0;
         r_cmd_addr <= 5'd0;
         r_io_out   <= 1'b0;
         r_oe       <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_shift    <= w_shift_n;
         r_rdata    <= w_rdata_n;
         r_cmd_ram  <= w_cmd_ram_n;
         r_cmd_addr <= w_cmd_addr_n;
         r_io_out   <= w_io_out_n;
         r_oe       <= w_oe_n;
         r_done     <= w_done_n;
      end
   end

   // Next state: command shift/decode, write commit, read drive
   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_shift_n    = r_shift;
      w_rdata_n    = r_rdata;
      w_cmd_ram_n  = r_cmd_ram;
      w_cmd_addr_n = r_cmd_addr;
      w_io_out_n   = r_io_out;
      w_oe_n       = r_oe;
      w_done_n     = 1'b0;
      w_commit     = 1'b0;
      if (!w_ce_s) begin
         w_state_n = ST_IDLE;
         w_cnt_n   = 4'd0;
         w_oe_n    = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ce_rise) begin
                  w_state_n = ST_CMD;
                  w_cnt_n   = 4'd0;
               end
            end
            ST_CMD: begin
               if (w_sclk_rise) begin
                  w_shift_n = w_byte[7:1];
                  w_cnt_n   = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     w_cnt_n      = 4'd0;
                     w_cmd_ram_n  = w_byte[CMD_RAM];
                     w_cmd_addr_n = w_addr;
                     if (!w_byte[CMD_MARK] || w_addr == ADDR_BURST)
                        w_state_n = ST_DONE;
                     else if (w_byte[CMD_RD]) begin
                        w_state_n = ST_RDATA;
                        w_rdata_n = w_rd_val;
                     end else
                        w_state_n = ST_WDATA;
                  end
               end
            end
            ST_WDATA: begin
               if (w_sclk_rise) begin
                  w_shift_n = w_byte[7:1];
                  w_cnt_n   = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     w_commit  = ~w_blocked;
                     w_done_n  = ~w_blocked;
                     w_state_n = ST_DONE;
                  end
               end
            end
            ST_RDATA: begin
               if (w_sclk_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_oe_n     = 1'b0;
                     w_io_out_n = 1'b0;
                     w_done_n   = 1'b1;
                     w_state_n  = ST_DONE;
                  end else begin
                     w_io_out_n = r_rdata[r_cnt[2:0]];
                     w_oe_n     = 1'b1;
                     w_cnt_n    = r_cnt + 4'd1;
                  end
               end
            end
            ST_DONE: begin
               w_state_n = ST_DONE;
            end
            default: begin
               w_state_n = ST_IDLE;
            end
         endcase
      end
   end

   assign w_wr_ck   = w_commit & ~r_cmd_ram;
   assign w_wr_sec  = w_wr_ck & (r_cmd_addr == ADDR_SEC);
   assign w_wr_min  = w_wr_ck & (r_cmd_addr == ADDR_MIN);
   assign w_wr_hour = w_wr_ck & (r_cmd_addr == ADDR_HOUR);

   // Calendar and control registers outside the timekeeper
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_date  <= RST_DATE;
         r_month <= RST_MONTH;
         r_day   <= RST_DAY;
         r_year  <= RST_YEAR;
         r_tcs   <= RST_TCS;
         r_wp    <= 1'b0;
      end else if (w_wr_ck) begin
         case (r_cmd_addr)
            ADDR_DATE:  r_date  <= w_byte;
            ADDR_MONTH: r_month <= w_byte;
            ADDR_DAY:   r_day   <= w_byte;
            ADDR_YEAR:  r_year  <= w_byte;
            ADDR_CTRL:  r_wp    <= w_byte[7];
            ADDR_TCS:   r_tcs   <= w_byte;
            default:    ;
         endcase
      end
   end

   ds1302_bcd_clock #(
      .CLK_HZ (CLK_HZ)
   ) u_clock (
      .i_clk     (sys_clk),
      .i_rst     (rst),
      .i_wr_sec  (w_wr_sec),
      .i_wr_min  (w_wr_min),
      .i_wr_hour (w_wr_hour),
      .i_wdata   (w_byte),
      .o_sec     (w_sec),
      .o_min     (w_min),
      .o_hour    (w_hour),
      .o_tick    (tick_1hz)
   );

   assign ds_io_out   = r_io_out;
   assign ds_io_oe    = r_oe;
   assign access_done = r_done;

endmodule
